// File: rtl/discus_loader_pkg.sv
// Shared opcode and state constants for the discus snoop-port loader.
// Command byte [7:6] selects the operation.
package discus_loader_pkg;

  localparam logic [1:0] OP_WPROG = 2'b00;
  localparam logic [1:0] OP_WDATA = 2'b01;
  localparam logic [1:0] OP_RDATA = 2'b10;
  localparam logic [1:0] OP_CTRL  = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t ADDR   = 3'd1;
  localparam state_t LEN    = 3'd2;
  localparam state_t WDATA  = 3'd3;
  localparam state_t RISSUE = 3'd4;
  localparam state_t RCAPT  = 3'd5;
  localparam state_t RSEND  = 3'd6;

endpackage

// File: rtl/discus_loader.sv
// Host byte-stream command decoder driving the discus snoop port.
// Turns block commands into program/data writes and data read-back, and owns the CPU reset line.
module discus_loader
  import discus_loader_pkg::*;
#(
  parameter logic CPU_RESET_INIT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] snoopa,
  output logic [7:0] snoopd,
  output logic       snoopm,
  output logic       snoopp,
  input  logic [7:0] snoopq,
  output logic       cpu_reset,
  output logic       busy
);

  state_t     state;
  logic [1:0] op;
  logic [7:0] addr;
  logic [7:0] count;
  logic       in_fire;

  assign in_ready = (state == IDLE) || (state == ADDR) || (state == LEN) || (state == WDATA);
  assign in_fire  = in_valid && in_ready;
  assign busy     = (state != IDLE);

  // Strobes are one-cycle pulses registered from a WDATA accept; count holds
  // remaining transfers minus one so a length byte of 0 gives 256 transfers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op        <= OP_WPROG;
      addr      <= 8'd0;
      count     <= 8'd0;
      out_data  <= 8'd0;
      out_valid <= 1'b0;
      snoopa    <= 8'd0;
      snoopd    <= 8'd0;
      snoopm    <= 1'b0;
      snoopp    <= 1'b0;
      cpu_reset <= CPU_RESET_INIT;
    end else begin
      snoopm <= 1'b0;
      snoopp <= 1'b0;
      case (state)
        IDLE: begin
          if (in_fire) begin
            if (in_data[7:6] == OP_CTRL) begin
              cpu_reset <= in_data[0];
            end else begin
              op    <= in_data[7:6];
              state <= ADDR;
            end
          end
        end
        ADDR: begin
          if (in_fire) begin
            addr  <= in_data;
            state <= LEN;
          end
        end
        LEN: begin
          if (in_fire) begin
            count <= in_data - 8'd1;
            if (op == OP_RDATA) begin
              snoopa <= addr;
              state  <= RISSUE;
            end else begin
              state <= WDATA;
            end
          end
        end
        WDATA: begin
          if (in_fire) begin
            snoopa <= addr;
            snoopd <= in_data;
            snoopp <= (op == OP_WPROG);
            snoopm <= (op == OP_WDATA);
            addr   <= addr + 8'd1;
            if (count == 8'd0) begin
              state <= IDLE;
            end else begin
              count <= count - 8'd1;
            end
          end
        end
        RISSUE: begin
          state <= RCAPT;
        end
        // snoopq reflects the address presented during RISSUE
        RCAPT: begin
          out_data  <= snoopq;
          out_valid <= 1'b1;
          state     <= RSEND;
        end
        RSEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            addr      <= addr + 8'd1;
            if (count == 8'd0) begin
              state <= IDLE;
            end else begin
              count  <= count - 8'd1;
              snoopa <= addr + 8'd1;
              state  <= RISSUE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_discus_loader.sv
// Self-checking bench for discus_loader: models program/data memories behind the snoop port
// and compares strobes and read-back bytes against a command-level reference model.
module tb_discus_loader;

  typedef struct packed {
    logic       prog;
    logic [7:0] a;
    logic [7:0] d;
  } strobe_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] snoopa;
  logic [7:0] snoopd;
  logic       snoopm;
  logic       snoopp;
  logic [7:0] snoopq;
  logic       cpu_reset;
  logic       busy;

  logic [7:0] dmem [256];
  logic [7:0] pmem [256];
  logic [7:0] exp_dmem [256];
  logic [7:0] exp_pmem [256];

  strobe_t    got_strobes[$];
  strobe_t    exp_strobes[$];
  int         got_cyc[$];
  logic [7:0] got_reads[$];
  logic [7:0] exp_reads[$];
  logic [7:0] payload[$];

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   overlap_cnt = 0;
  int   unstable_cnt = 0;
  int   ready_mode = 1;
  bit   busy_seen = 0;
  bit   prev_stall = 0;
  logic [7:0] prev_data = 8'd0;

  discus_loader #(.CPU_RESET_INIT(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .snoopa    (snoopa),
    .snoopd    (snoopd),
    .snoopm    (snoopm),
    .snoopp    (snoopp),
    .snoopq    (snoopq),
    .cpu_reset (cpu_reset),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural discus memories: synchronous writes, registered data-memory read
  always @(posedge clk) begin
    if (snoopm) dmem[snoopa] <= snoopd;
    if (snoopp) pmem[snoopa] <= snoopd;
    snoopq <= dmem[snoopa];
  end

  always @(negedge clk) begin
    case (ready_mode)
      0:       out_ready <= 1'b0;
      1:       out_ready <= 1'b1;
      default: out_ready <= ($urandom_range(0, 2) != 0);
    endcase
  end

  // Observes the DUT mid-cycle: strobes, output transfers, output stability
  initial forever begin
    strobe_t s;
    @(negedge clk);
    #1;
    if (snoopm && snoopp) overlap_cnt++;
    if (busy) busy_seen = 1;
    if (snoopm || snoopp) begin
      s.prog = snoopp;
      s.a    = snoopa;
      s.d    = snoopd;
      got_strobes.push_back(s);
      got_cyc.push_back(cyc);
    end
    if (out_valid && out_ready) got_reads.push_back(out_data);
    if (!reset && prev_stall && (!out_valid || out_data !== prev_data)) unstable_cnt++;
    prev_stall = !reset && out_valid && !out_ready;
    prev_data  = out_data;
  end

  initial begin
    #800000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int strobe_errs();
    int e;
    e = (got_strobes.size() == exp_strobes.size()) ? 0 : 1;
    for (int i = 0; i < got_strobes.size() && i < exp_strobes.size(); i++)
      if (got_strobes[i] !== exp_strobes[i]) e++;
    return e;
  endfunction

  function automatic int read_errs();
    int e;
    e = (got_reads.size() == exp_reads.size()) ? 0 : 1;
    for (int i = 0; i < got_reads.size() && i < exp_reads.size(); i++)
      if (got_reads[i] !== exp_reads[i]) e++;
    return e;
  endfunction

  task automatic clear_obs();
    got_strobes.delete();
    exp_strobes.delete();
    got_cyc.delete();
    got_reads.delete();
    exp_reads.delete();
    overlap_cnt  = 0;
    unstable_cnt = 0;
    busy_seen    = 0;
  endtask

  // Reference model: a write block lands payload bytes at consecutive wrapping addresses
  task automatic model_write(input bit prog, input logic [7:0] a, input int n);
    strobe_t s;
    for (int i = 0; i < n; i++) begin
      s.prog = prog;
      s.a    = a + 8'(i);
      s.d    = payload[i];
      if (prog) exp_pmem[s.a] = s.d;
      else exp_dmem[s.a] = s.d;
      exp_strobes.push_back(s);
    end
  endtask

  task automatic model_read(input logic [7:0] a, input int n);
    for (int i = 0; i < n; i++) exp_reads.push_back(exp_dmem[a + 8'(i)]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done = 0;
    in_data  = b;
    in_valid = 1'b1;
    for (int t = 0; t < 500 && !done; t++) begin
      #1;
      if (in_ready) done = 1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("[TB] FAIL in_accept got=not_accepted want=accepted byte=%02h", b);
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] a, input int n);
    send_byte({op, 6'd0});
    send_byte(a);
    send_byte(8'(n));
    if (op != 2'b10)
      for (int i = 0; i < n; i++) send_byte(payload[i]);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int t = 0; t < 3000 && !done; t++) begin
      if (!busy) done = 1;
      else @(negedge clk);
    end
    checks++;
    if (!done) begin
      failures++;
      $display("[TB] FAIL idle_wait got=busy want=idle");
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 9;
    if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_out_valid got=%b want=0", out_valid); end
    if (out_data !== 8'h00) begin failures++; $display("[TB] FAIL rst_out_data got=%02h want=00", out_data); end
    if (snoopm !== 1'b0) begin failures++; $display("[TB] FAIL rst_snoopm got=%b want=0", snoopm); end
    if (snoopp !== 1'b0) begin failures++; $display("[TB] FAIL rst_snoopp got=%b want=0", snoopp); end
    if (snoopa !== 8'h00) begin failures++; $display("[TB] FAIL rst_snoopa got=%02h want=00", snoopa); end
    if (snoopd !== 8'h00) begin failures++; $display("[TB] FAIL rst_snoopd got=%02h want=00", snoopd); end
    if (cpu_reset !== 1'b1) begin failures++; $display("[TB] FAIL rst_cpu_reset got=%b want=1", cpu_reset); end
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy got=%b want=0", busy); end
    if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_control();
    clear_obs();
    send_byte(8'hC0);
    checks++;
    if (cpu_reset !== 1'b0) begin failures++; $display("[TB] FAIL ctrl_c0 got=%b want=0", cpu_reset); end
    send_byte(8'hC1);
    checks++;
    if (cpu_reset !== 1'b1) begin failures++; $display("[TB] FAIL ctrl_c1 got=%b want=1", cpu_reset); end
    send_byte(8'hFE);
    checks++;
    if (cpu_reset !== 1'b0) begin failures++; $display("[TB] FAIL ctrl_fe got=%b want=0", cpu_reset); end
    send_byte(8'hFF);
    checks++;
    if (cpu_reset !== 1'b1) begin failures++; $display("[TB] FAIL ctrl_ff got=%b want=1", cpu_reset); end
    repeat (2) @(negedge clk);
    checks++;
    if (busy_seen !== 1'b0) begin failures++; $display("[TB] FAIL ctrl_busy got=%b want=0", busy_seen); end
  endtask

  task automatic test_prog_write();
    clear_obs();
    payload = '{8'h11, 8'h22, 8'h33};
    model_write(1'b1, 8'hFE, 3);
    send_cmd(2'b00, 8'hFE, 3);
    wait_idle();
    checks += 5;
    if (strobe_errs() != 0) begin failures++; $display("[TB] FAIL prog_strobes got=%0d want=%0d", got_strobes.size(), exp_strobes.size()); end
    if (got_cyc.size() != 3 || got_cyc[2] - got_cyc[0] != 2) begin failures++; $display("[TB] FAIL prog_b2b got=%0d want=2", got_cyc.size() == 3 ? got_cyc[2] - got_cyc[0] : -1); end
    if (pmem[8'h00] !== 8'h33) begin failures++; $display("[TB] FAIL prog_wrap got=%02h want=33", pmem[8'h00]); end
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL prog_busy got=%b want=0", busy); end
    if (overlap_cnt != 0) begin failures++; $display("[TB] FAIL prog_overlap got=%0d want=0", overlap_cnt); end
  endtask

  task automatic test_wrap256();
    int bad = 0;
    clear_obs();
    payload.delete();
    for (int i = 0; i < 256; i++) payload.push_back(8'(i));
    model_write(1'b0, 8'h00, 256);
    send_cmd(2'b01, 8'h00, 256);
    wait_idle();
    for (int i = 0; i < 256; i++) if (dmem[i] !== 8'(i)) bad++;
    checks += 4;
    if (strobe_errs() != 0) begin failures++; $display("[TB] FAIL wrap_strobes got=%0d want=%0d", got_strobes.size(), exp_strobes.size()); end
    if (bad != 0) begin failures++; $display("[TB] FAIL wrap_mem got=%0d want=0 bad bytes", bad); end
    if (got_cyc.size() != 256 || got_cyc[255] - got_cyc[0] != 255) begin failures++; $display("[TB] FAIL wrap_rate got=%0d want=256", got_cyc.size()); end
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL wrap_busy got=%b want=0", busy); end
  endtask

  task automatic test_read_stall();
    bit seen = 0;
    clear_obs();
    ready_mode = 1;
    payload = '{8'hA5, 8'h5A};
    model_write(1'b0, 8'h10, 2);
    send_cmd(2'b01, 8'h10, 2);
    wait_idle();
    ready_mode = 0;
    repeat (2) @(negedge clk);
    model_read(8'h10, 2);
    send_cmd(2'b10, 8'h10, 2);
    for (int t = 0; t < 50 && !seen; t++) begin
      if (out_valid) seen = 1;
      else @(negedge clk);
    end
    repeat (5) @(negedge clk);
    checks += 2;
    if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL rd_hold_valid got=%b want=1", out_valid); end
    if (out_data !== 8'hA5) begin failures++; $display("[TB] FAIL rd_hold_data got=%02h want=a5", out_data); end
    ready_mode = 1;
    wait_idle();
    checks += 3;
    if (read_errs() != 0) begin failures++; $display("[TB] FAIL rd_bytes got=%0d want=%0d", got_reads.size(), exp_reads.size()); end
    if (got_reads.size() != 2 || got_reads[1] !== 8'h5A) begin failures++; $display("[TB] FAIL rd_second got=%0d want=2 bytes", got_reads.size()); end
    if (unstable_cnt != 0) begin failures++; $display("[TB] FAIL rd_stable got=%0d want=0", unstable_cnt); end
  endtask

  task automatic test_payload_ctrl_byte();
    logic cpu_before;
    clear_obs();
    cpu_before = cpu_reset;
    payload = '{8'hC0};
    model_write(1'b0, 8'h30, 1);
    send_cmd(2'b01, 8'h30, 1);
    wait_idle();
    checks += 2;
    if (dmem[8'h30] !== 8'hC0) begin failures++; $display("[TB] FAIL payload_c0 got=%02h want=c0", dmem[8'h30]); end
    if (cpu_reset !== cpu_before) begin failures++; $display("[TB] FAIL payload_cpu got=%b want=%b", cpu_reset, cpu_before); end
  endtask

  task automatic test_reset_mid();
    send_byte(8'hC0);
    clear_obs();
    payload = '{8'h3C, 8'hC3};
    model_write(1'b0, 8'h20, 2);
    send_byte(8'h40);
    send_byte(8'h20);
    send_byte(8'h04);
    send_byte(8'h3C);
    send_byte(8'hC3);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h99;
    @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    checks += 4;
    if (snoopm !== 1'b0 || snoopp !== 1'b0) begin failures++; $display("[TB] FAIL mid_strobe got=%b%b want=00", snoopm, snoopp); end
    if (cpu_reset !== 1'b1) begin failures++; $display("[TB] FAIL mid_cpu_reset got=%b want=1", cpu_reset); end
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL mid_busy got=%b want=0", busy); end
    if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_out_valid got=%b want=0", out_valid); end
    repeat (4) @(negedge clk);
    checks += 2;
    if (strobe_errs() != 0) begin failures++; $display("[TB] FAIL mid_writes got=%0d want=%0d", got_strobes.size(), exp_strobes.size()); end
    if (dmem[8'h22] !== exp_dmem[8'h22]) begin failures++; $display("[TB] FAIL mid_untouched got=%02h want=%02h", dmem[8'h22], exp_dmem[8'h22]); end
    ready_mode = 1;
    model_read(8'h20, 1);
    send_cmd(2'b10, 8'h20, 1);
    wait_idle();
    checks++;
    if (got_reads.size() != 1 || got_reads[0] !== 8'h3C) begin failures++; $display("[TB] FAIL mid_readback got=%0d bytes want=1 byte 3c", got_reads.size()); end
  endtask

  task automatic test_random();
    int bad = 0;
    clear_obs();
    ready_mode = 2;
    for (int k = 0; k < 16; k++) begin
      logic [1:0] op;
      logic [7:0] a;
      int n;
      op = 2'($urandom_range(0, 2));
      a  = 8'($urandom);
      n  = $urandom_range(1, 6);
      payload.delete();
      if (op != 2'b10) begin
        for (int i = 0; i < n; i++) payload.push_back(8'($urandom));
        model_write(op == 2'b00, a, n);
      end else begin
        model_read(a, n);
      end
      send_cmd(op, a, n);
      wait_idle();
    end
    ready_mode = 1;
    for (int i = 0; i < 256; i++) if (dmem[i] !== exp_dmem[i] || pmem[i] !== exp_pmem[i]) bad++;
    checks += 5;
    if (strobe_errs() != 0) begin failures++; $display("[TB] FAIL rnd_strobes got=%0d want=%0d", got_strobes.size(), exp_strobes.size()); end
    if (read_errs() != 0) begin failures++; $display("[TB] FAIL rnd_reads got=%0d want=%0d", got_reads.size(), exp_reads.size()); end
    if (bad != 0) begin failures++; $display("[TB] FAIL rnd_mem got=%0d want=0 bad bytes", bad); end
    if (overlap_cnt != 0) begin failures++; $display("[TB] FAIL rnd_overlap got=%0d want=0", overlap_cnt); end
    if (unstable_cnt != 0) begin failures++; $display("[TB] FAIL rnd_stable got=%0d want=0", unstable_cnt); end
  endtask

  initial begin
    $display("[TB] discus_loader bench start");
    test_reset();
    test_control();
    test_prog_write();
    test_wrap256();
    test_read_stall();
    test_payload_ctrl_byte();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
